// File: rtl/mpu_window_packer.sv
// mpu_window_packer: detects motion onset against a running idle baseline,
// captures a 30-sample window and presents it as a packed 960-bit bus.
module mpu_window_packer #(
    parameter int MOTION_THRESH = 200,
    parameter int TIMEOUT       = 1000,
    parameter int MOV_HOLD      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic [31:0]  sample_data,
    input  logic [4:0]   ldr_in,
    output logic [959:0] mpu,
    output logic [4:0]   ldr_out,
    output logic         mov,
    output logic         abort
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(MOV_HOLD + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} state_t;

    state_t        state_q;
    logic [31:0]   buf_q [30];
    logic [31:0]   base_q;
    logic          base_valid_q;
    logic [4:0]    count_q;
    logic [TW-1:0] timer_q;
    logic [HW-1:0] hold_q;
    logic [32:0]   diff, mag;
    logic          accept, trig;

    assign accept = sample_valid && sample_ready;
    // sign-extend to 33 bits so extreme opposite-sign samples cannot wrap
    assign diff   = {sample_data[31], sample_data} - {base_q[31], base_q};
    assign mag    = diff[32] ? -diff : diff;
    assign trig   = mag > 33'(MOTION_THRESH);

    for (genvar i = 0; i < 30; i++) begin : g_pack
        assign mpu[32*i +: 32] = buf_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int k = 0; k < 30; k++) buf_q[k] <= '0;
            base_q       <= '0;
            base_valid_q <= 1'b0;
            count_q      <= '0;
            timer_q      <= '0;
            hold_q       <= '0;
            ldr_out      <= '0;
            mov          <= 1'b0;
            abort        <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            abort <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    if (!base_valid_q) begin
                        base_q       <= sample_data;
                        base_valid_q <= 1'b1;
                    end else if (trig) begin
                        buf_q[0] <= sample_data;
                        count_q  <= 5'd1;
                        timer_q  <= '0;
                        state_q  <= CAPTURE;
                    end else begin
                        base_q <= sample_data;
                    end
                end
                CAPTURE: if (accept) begin
                    buf_q[count_q] <= sample_data;
                    timer_q        <= '0;
                    if (count_q == 5'd29) begin
                        ldr_out      <= ldr_in;
                        count_q      <= '0;
                        hold_q       <= '0;
                        mov          <= 1'b1;
                        sample_ready <= 1'b0;
                        state_q      <= PRESENT;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    abort   <= 1'b1;
                    count_q <= '0;
                    timer_q <= '0;
                    state_q <= IDLE;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
                PRESENT: if (hold_q == HW'(MOV_HOLD - 1)) begin
                    mov          <= 1'b0;
                    sample_ready <= 1'b1;
                    base_q       <= buf_q[29];
                    state_q      <= IDLE;
                end else begin
                    hold_q <= hold_q + HW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpu_window_packer.sv
// tb_mpu_window_packer: randomized scenarios checked against a transaction-level
// model of baseline tracking, triggering and window capture.
module tb_mpu_window_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic [31:0]  sample_data = '0;
    logic [4:0]   ldr_in = '0;
    logic [959:0] mpu;
    logic [4:0]   ldr_out;
    logic         mov;
    logic         abort;

    int pass_cnt = 0;
    int total = 0;

    logic [31:0] m_base;
    bit          m_bv, m_cap;
    int          m_cnt;
    logic [31:0] m_win [30];

    mpu_window_packer dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .ldr_in(ldr_in), .mpu(mpu), .ldr_out(ldr_out),
        .mov(mov), .abort(abort)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void model_reset();
        m_base = '0;
        m_bv   = 0;
        m_cap  = 0;
        m_cnt  = 0;
        for (int i = 0; i < 30; i++) m_win[i] = '0;
    endfunction

    // returns 1 when this sample completes a window
    function automatic bit model_step(input logic [31:0] d);
        longint dd;
        if (m_cap) begin
            m_win[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 30) begin
                m_cap  = 0;
                m_cnt  = 0;
                m_base = m_win[29];
                return 1;
            end
            return 0;
        end
        if (!m_bv) begin
            m_base = d;
            m_bv   = 1;
            return 0;
        end
        dd = longint'($signed(d)) - longint'($signed(m_base));
        if (dd < 0) dd = -dd;
        if (dd > 200) begin
            m_win[0] = d;
            m_cnt    = 1;
            m_cap    = 1;
        end else begin
            m_base = d;
        end
        return 0;
    endfunction

    function automatic logic [959:0] model_mpu();
        logic [959:0] m;
        for (int i = 0; i < 30; i++) m[32*i +: 32] = m_win[i];
        return m;
    endfunction

    function automatic logic [31:0] rnd();
        return 32'($urandom_range(0, 200000)) - 32'd100000;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [31:0] d, output bit done);
        int w = 0;
        while (!sample_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        done = 0;
        if (!sample_ready) begin
            total++;
            $display("FAIL ready_wait: sample_ready=%b required 1", sample_ready);
            return;
        end
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        done = model_step(d);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (mov !== 1'b0) $display("FAIL reset_mov: got %b required 0", mov); else pass_cnt++;
        total++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b required 0", abort); else pass_cnt++;
        total++; if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", sample_ready); else pass_cnt++;
        total++; if (mpu !== '0) $display("FAIL reset_mpu: got %h required 0", mpu[63:0]); else pass_cnt++;
        total++; if (ldr_out !== 5'd0) $display("FAIL reset_ldr: got %b required 0", ldr_out); else pass_cnt++;
    endtask

    task automatic test_no_trigger();
        logic [31:0] s [4];
        bit d;
        s[0] = 32'd0; s[1] = 32'd10; s[2] = -32'sd20; s[3] = 32'd150;
        for (int i = 0; i < 4; i++) begin
            send(s[i], d);
            total++;
            if (mov !== 1'b0 || sample_ready !== 1'b1)
                $display("FAIL idle_track[%0d]: mov=%b ready=%b required 0/1", i, mov, sample_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_threshold();
        bit d;
        send(32'd350, d);
        send(32'd149, d);
        for (int i = 0; i < 29; i++) begin
            send(rnd(), d);
            total++;
            if (mov !== d) $display("FAIL thresh_mov[%0d]: got %b required %b", i, mov, d); else pass_cnt++;
        end
        total++; if (mpu[31:0] !== 32'd149) $display("FAIL thresh_slot0: got %0d required 149", $signed(mpu[31:0])); else pass_cnt++;
        apply_reset();
        send(32'h7fffffff, d);
        send(32'h80000000, d);
        for (int i = 0; i < 29; i++) send(rnd(), d);
        total++; if (mov !== 1'b1) $display("FAIL wide_diff_trigger: mov=%b required 1", mov); else pass_cnt++;
        total++; if (mpu !== model_mpu()) $display("FAIL wide_diff_mpu: got %h required %h", mpu[63:0], model_mpu() & 960'hFFFFFFFFFFFFFFFF); else pass_cnt++;
    endtask

    task automatic test_spec_window();
        bit d;
        apply_reset();
        ldr_in = 5'd0;
        send(32'd0, d);
        send(32'd201, d);
        for (int i = 0; i < 29; i++) begin
            if (i == 28) ldr_in = 5'b00010;
            send(-32'sd865, d);
            total++;
            if (mov !== d) $display("FAIL spec_mov_rise[%0d]: got %b required %b", i, mov, d); else pass_cnt++;
        end
        ldr_in = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            total++; if (mov !== 1'b1 || sample_ready !== 1'b0) $display("FAIL spec_hold[%0d]: mov=%b ready=%b required 1/0", k, mov, sample_ready); else pass_cnt++;
            total++; if (mpu[31:0] !== 32'd201 || mpu[959:928] !== 32'hFFFFFC9F) $display("FAIL spec_mpu[%0d]: slot0=%h slot29=%h required 000000c9/fffffc9f", k, mpu[31:0], mpu[959:928]); else pass_cnt++;
            total++; if (ldr_out !== 5'b00010) $display("FAIL spec_ldr[%0d]: got %b required 00010", k, ldr_out); else pass_cnt++;
            @(posedge clk); #1;
        end
        total++; if (mov !== 1'b0 || sample_ready !== 1'b1) $display("FAIL spec_release: mov=%b ready=%b required 0/1", mov, sample_ready); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit d, bad;
        logic [31:0] t;
        send(m_base + 32'd500, d);
        for (int i = 0; i < 10; i++) send(rnd(), d);
        bad = 0;
        for (int i = 0; i < 999; i++) begin
            @(posedge clk); #1;
            if (abort !== 1'b0 || mov !== 1'b0) bad = 1;
        end
        total++; if (bad) $display("FAIL timeout_early: abort or mov rose before timeout, required 0"); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (abort !== 1'b1) $display("FAIL timeout_pulse: abort=%b required 1", abort); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (abort !== 1'b0 || sample_ready !== 1'b1) $display("FAIL timeout_once: abort=%b ready=%b required 0/1", abort, sample_ready); else pass_cnt++;
        m_cap = 0;
        m_cnt = 0;
        t = m_base + 32'd300;
        send(t, d);
        for (int i = 0; i < 29; i++) begin
            send(rnd(), d);
            total++;
            if (mov !== d) $display("FAIL retrigger_mov[%0d]: got %b required %b", i, mov, d); else pass_cnt++;
        end
        total++; if (mpu !== model_mpu() || mpu[31:0] !== t) $display("FAIL retrigger_mpu: slot0=%h required %h", mpu[31:0], t); else pass_cnt++;
    endtask

    task automatic test_late_sample();
        bit d;
        send(m_base + 32'd1000, d);
        for (int i = 0; i < 5; i++) send(rnd(), d);
        repeat (999) begin
            @(posedge clk); #1;
        end
        send(rnd(), d);
        total++; if (abort !== 1'b0 || mov !== 1'b0) $display("FAIL late_sample: abort=%b mov=%b required 0/0", abort, mov); else pass_cnt++;
        for (int i = 0; i < 8; i++) send(rnd(), d);
        total++; if (m_cnt !== 15 || mpu[32*14 +: 32] !== m_win[14]) $display("FAIL partial_slot14: got %h required %h", mpu[32*14 +: 32], m_win[14]); else pass_cnt++;
        #3 reset = 1'b1;
        #1;
        total++; if (mpu !== '0 || mov !== 1'b0 || abort !== 1'b0 || sample_ready !== 1'b1 || ldr_out !== 5'd0)
            $display("FAIL async_reset: mov=%b abort=%b ready=%b ldr=%b mpu_lo=%h required 0/0/1/0/0", mov, abort, sample_ready, ldr_out, mpu[63:0]);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        bit d;
        logic [959:0] snap;
        logic [31:0] e;
        send(32'd1000, d);
        send(32'd1250, d);
        for (int i = 0; i < 28; i++) send(rnd(), d);
        sample_valid = 1'b1;
        sample_data  = 32'd50000;
        @(posedge clk); #1;
        d = model_step(32'd50000);
        snap = model_mpu();
        sample_data = 32'd50150;
        for (int k = 0; k < 4; k++) begin
            total++; if (sample_ready !== 1'b0 || mov !== 1'b1) $display("FAIL b2b_stall[%0d]: ready=%b mov=%b required 0/1", k, sample_ready, mov); else pass_cnt++;
            total++; if (mpu !== snap) $display("FAIL b2b_mpu[%0d]: slot29=%h required %h", k, mpu[959:928], snap[959:928]); else pass_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        d = model_step(32'd50150);
        e = 32'd50351;
        send(e, d);
        for (int i = 0; i < 29; i++) begin
            send(rnd(), d);
            total++;
            if (mov !== d) $display("FAIL b2b_rebase_mov[%0d]: got %b required %b", i, mov, d); else pass_cnt++;
        end
        total++; if (mpu[31:0] !== e) $display("FAIL b2b_rebase_slot0: got %h required %h", mpu[31:0], e); else pass_cnt++;
    endtask

    task automatic test_random_windows();
        bit d;
        logic [4:0] l;
        for (int w = 0; w < 5; w++) begin
            for (int j = 0; j < 3; j++) begin
                send(m_base + 32'($urandom_range(0, 400)) - 32'd200, d);
                total++; if (mov !== 1'b0 || sample_ready !== 1'b1) $display("FAIL rnd_idle[%0d]: mov=%b ready=%b required 0/1", w, mov, sample_ready); else pass_cnt++;
            end
            if ($urandom_range(0, 1) == 1) send(m_base + 32'd201 + 32'($urandom_range(0, 5000)), d);
            else send(m_base - 32'd201 - 32'($urandom_range(0, 5000)), d);
            l = '0;
            for (int i = 0; i < 29; i++) begin
                l = 5'($urandom);
                ldr_in = l;
                send(rnd(), d);
                total++;
                if (mov !== d) $display("FAIL rnd_mov[%0d.%0d]: got %b required %b", w, i, mov, d); else pass_cnt++;
            end
            ldr_in = ~l;
            total++; if (mpu !== model_mpu()) $display("FAIL rnd_mpu[%0d]: slot29=%h required %h", w, mpu[959:928], m_win[29]); else pass_cnt++;
            total++; if (ldr_out !== l) $display("FAIL rnd_ldr[%0d]: got %b required %b", w, ldr_out, l); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_no_trigger();
        test_threshold();
        test_spec_window();
        test_timeout();
        test_late_sample();
        test_back_to_back();
        test_random_windows();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
